// File: rtl/bnn_fc_mac.sv
// Binarised fully-connected multiply-accumulate block.
// Activations and weights are single bits (1 = +1, 0 = -1). Each accepted beat
// adds IN_LANES XNOR products per output neuron into a signed accumulator.
// After STEPS beats, the result is presented as signed sums and sign bits. It
// is held until the consumer accepts it.
module bnn_fc_mac #(
    parameter int IN_LANES = 3,
    parameter int STEPS    = 36,
    parameter int NUM_OUT  = 2,
    parameter int ACC_W    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         w_we,
    input  logic [$clog2(STEPS)-1:0]     w_addr,
    input  logic [NUM_OUT*IN_LANES-1:0]  w_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [IN_LANES-1:0]          in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_OUT*ACC_W-1:0]     acc_out,
    output logic [NUM_OUT-1:0]           sign_out,
    output logic                         busy
);

    localparam int AW    = $clog2(STEPS);
    localparam int ROW_W = NUM_OUT * IN_LANES;

    localparam logic [AW:0]             STEPS_L   = (AW+1)'(STEPS);
    localparam logic [AW-1:0]           LAST_STEP = AW'(STEPS - 1);
    localparam logic signed [ACC_W-1:0] PLUS1     = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] MINUS1    = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           step_q;
    logic [ROW_W-1:0]        w_mem [STEPS];
    logic signed [ACC_W-1:0] acc_q [NUM_OUT];
    logic signed [ACC_W-1:0] contrib [NUM_OUT];
    logic [ROW_W-1:0]        w_row;
    logic                    beat;
    logic                    last_step;
    logic                    w_ok;

    // Signed sum of +1/-1 XNOR products across the lanes of one beat
    function automatic logic signed [ACC_W-1:0] beat_sum(
        input logic [IN_LANES-1:0] act,
        input logic [IN_LANES-1:0] wgt
    );
        logic signed [ACC_W-1:0] s;
        s = '0;
        for (int l = 0; l < IN_LANES; l++) begin
            s = s + ((act[l] ~^ wgt[l]) ? PLUS1 : MINUS1);
        end
        return s;
    endfunction

    assign in_ready  = (state_q != DONE);
    assign beat      = in_valid && in_ready;
    assign last_step = (step_q == LAST_STEP);
    assign w_ok      = ({1'b0, w_addr} < STEPS_L);
    assign w_row     = w_mem[step_q];
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    // ---- stage: beat contribution from the current weight row ----
    // Per-output contribution of the beat currently on in_data
    always_comb begin
        for (int o = 0; o < NUM_OUT; o++) begin
            contrib[o] = beat_sum(in_data, w_row[o*IN_LANES +: IN_LANES]);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear overrides any beat or out_ready
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (beat) state_d = last_step ? DONE : ACC;
                ACC:     if (beat && last_step) state_d = DONE;
                DONE:    if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // ---- stage: accumulate ----
    // Accumulators and step counter; the first beat of a vector loads rather than adds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
            for (int o = 0; o < NUM_OUT; o++) acc_q[o] <= '0;
        end else if (clear) begin
            step_q <= '0;
            for (int o = 0; o < NUM_OUT; o++) acc_q[o] <= '0;
        end else if (beat) begin
            step_q <= last_step ? '0 : step_q + AW'(1);
            for (int o = 0; o < NUM_OUT; o++) begin
                acc_q[o] <= (state_q == IDLE) ? contrib[o] : acc_q[o] + contrib[o];
            end
        end
    end

    // Weight rows are written only while idle and not starting a vector on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STEPS; s++) w_mem[s] <= '0;
        end else if (w_we && (state_q == IDLE) && !beat && w_ok) begin
            w_mem[w_addr] <= w_data;
        end
    end

    // ---- stage: result presentation ----
    // Pack sums and binarise; sign bits are only meaningful while a result is valid
    always_comb begin
        acc_out  = '0;
        sign_out = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            acc_out[o*ACC_W +: ACC_W] = acc_q[o];
            sign_out[o]               = out_valid & ~acc_q[o][ACC_W-1];
        end
    end

endmodule

// File: tb/tb_bnn_fc_mac.sv
// Testbench for bnn_fc_mac: table-driven uniform vectors, randomized vectors
// against a bit-level reference sum, and directed stall/clear/reset sequences.
module tb_bnn_fc_mac;

    localparam int LANES = 3;
    localparam int STEPS = 36;
    localparam int NO    = 2;
    localparam int ACCW  = 8;
    localparam int AW    = $clog2(STEPS);
    localparam int RW    = NO * LANES;

    logic              clk = 0;
    logic              rst_n = 0;
    logic              clear = 0;
    logic              w_we = 0;
    logic [AW-1:0]     w_addr = '0;
    logic [RW-1:0]     w_data = '0;
    logic              in_valid = 0;
    logic              in_ready;
    logic [LANES-1:0]  in_data = '0;
    logic              out_valid;
    logic              out_ready = 0;
    logic [NO*ACCW-1:0] acc_out;
    logic [NO-1:0]     sign_out;
    logic              busy;

    bnn_fc_mac #(.IN_LANES(LANES), .STEPS(STEPS), .NUM_OUT(NO), .ACC_W(ACCW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .w_we(w_we), .w_addr(w_addr),
        .w_data(w_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
        .sign_out(sign_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // Reference model: weight rows as the block should hold them, and the vector sent
    logic [RW-1:0]    wm  [STEPS];
    logic [LANES-1:0] vec [STEPS];

    typedef struct {
        logic [RW-1:0]    row;
        logic [LANES-1:0] act;
        int               e0;
        int               e1;
        logic [NO-1:0]    es;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int get_acc(input int o);
        logic signed [ACCW-1:0] v;
        v = acc_out[o*ACCW +: ACCW];
        return int'(v);
    endfunction

    // Sum of +1/-1 products over every lane of every step
    function automatic int model_sum(input int o);
        int sum = 0;
        for (int s = 0; s < STEPS; s++)
            for (int l = 0; l < LANES; l++)
                sum += (vec[s][l] == wm[s][o*LANES + l]) ? 1 : -1;
        return sum;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_row(input int addr, input logic [RW-1:0] d);
        w_we = 1; w_addr = AW'(addr); w_data = d;
        tick();
        w_we = 0;
        if (addr < STEPS) wm[addr] = d;
    endtask

    task automatic write_all(input logic [RW-1:0] d);
        for (int s = 0; s < STEPS; s++) write_row(s, d);
    endtask

    // Send the first n beats of vec; optional random gaps and illegal weight writes
    task automatic send_beats(input int n, input int gap_max, input bit inject);
        for (int s = 0; s < n; s++) begin
            if (gap_max > 0) begin
                int g = $urandom_range(gap_max, 0);
                repeat (g) begin
                    in_valid = 0; in_data = LANES'($urandom);
                    tick();
                end
            end
            in_valid = 1; in_data = vec[s];
            if (inject && (s == 0 || s == 5)) begin
                w_we = 1; w_addr = AW'(s == 0 ? 10 : 7);
                w_data = ~wm[s == 0 ? 10 : 7];
            end
            tick();
            w_we = 0; in_valid = 0;
            if (s < STEPS - 1) chk("no_early_valid", int'(out_valid), 0);
        end
    endtask

    task automatic check_result(input string tag, input int e0, input int e1, input logic [NO-1:0] es);
        chk({tag, "_valid"}, int'(out_valid), 1);
        chk({tag, "_acc0"}, get_acc(0), e0);
        chk({tag, "_acc1"}, get_acc(1), e1);
        chk({tag, "_sign"}, int'(sign_out), int'(es));
    endtask

    // Hold out_ready low for wait_cyc cycles while offering beats, then consume
    task automatic release_result(input int wait_cyc, input int e0, input int e1, input logic [NO-1:0] es);
        out_ready = 0;
        repeat (wait_cyc) begin
            in_valid = 1; in_data = LANES'($urandom);
            tick();
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_ready", int'(in_ready), 0);
            chk("hold_acc0", get_acc(0), e0);
            chk("hold_acc1", get_acc(1), e1);
            chk("hold_sign", int'(sign_out), int'(es));
        end
        in_valid = 0; out_ready = 1;
        tick();
        out_ready = 0;
        chk("drop_valid", int'(out_valid), 0);
        chk("drop_busy", int'(busy), 0);
        chk("drop_ready", int'(in_ready), 1);
    endtask

    initial begin
        for (int s = 0; s < STEPS; s++) begin wm[s] = '0; vec[s] = '0; end
        tbl[0] = '{row: 6'b111111, act: 3'b111, e0:  108, e1:  108, es: 2'b11};
        tbl[1] = '{row: 6'b111111, act: 3'b000, e0: -108, e1: -108, es: 2'b00};
        tbl[2] = '{row: 6'b000111, act: 3'b111, e0:  108, e1: -108, es: 2'b01};
        tbl[3] = '{row: 6'b111000, act: 3'b111, e0: -108, e1:  108, es: 2'b10};
        tbl[4] = '{row: 6'b000111, act: 3'b101, e0:   36, e1:  -36, es: 2'b01};

        // Reset state
        #3;
        chk("rst_acc0", get_acc(0), 0);
        chk("rst_acc1", get_acc(1), 0);
        chk("rst_sign", int'(sign_out), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        tick();
        rst_n = 1;
        tick();
        chk("rst_in_ready", int'(in_ready), 1);

        // Uniform vectors from the table
        foreach (tbl[i]) begin
            write_all(tbl[i].row);
            for (int s = 0; s < STEPS; s++) vec[s] = tbl[i].act;
            send_beats(STEPS, 0, 0);
            check_result($sformatf("tbl%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].es);
            release_result(1, tbl[i].e0, tbl[i].e1, tbl[i].es);
        end

        // Stall scenario: half +1 half -1 gives zero, which binarises to +1
        write_all(6'b111111);
        for (int s = 0; s < STEPS; s++) vec[s] = (s < 18) ? 3'b111 : 3'b000;
        send_beats(STEPS, 3, 0);
        check_result("stall", 0, 0, 2'b11);
        release_result(5, 0, 0, 2'b11);

        // Randomized vectors against the reference model, with ignored weight writes
        for (int t = 0; t < 6; t++) begin
            int e0, e1;
            for (int s = 0; s < STEPS; s++) write_row(s, RW'($urandom));
            write_row(STEPS + t % (64 - STEPS), RW'($urandom));
            for (int s = 0; s < STEPS; s++) vec[s] = LANES'($urandom);
            send_beats(STEPS, (t % 2) ? 2 : 0, t >= 3);
            e0 = model_sum(0);
            e1 = model_sum(1);
            check_result($sformatf("rnd%0d", t), e0, e1, {e1 >= 0, e0 >= 0});
            release_result($urandom_range(3, 0), e0, e1, {e1 >= 0, e0 >= 0});
        end

        // Clear mid-vector, then a fresh vector with unchanged weights
        write_all(6'b111111);
        for (int s = 0; s < STEPS; s++) vec[s] = 3'b111;
        send_beats(10, 0, 0);
        chk("pre_clear_busy", int'(busy), 1);
        clear = 1; in_valid = 1; in_data = 3'b111;
        tick();
        clear = 0; in_valid = 0;
        chk("clear_busy", int'(busy), 0);
        chk("clear_valid", int'(out_valid), 0);
        chk("clear_acc0", get_acc(0), 0);
        chk("clear_acc1", get_acc(1), 0);
        send_beats(STEPS, 0, 0);
        check_result("after_clear", 108, 108, 2'b11);
        release_result(0, 108, 108, 2'b11);

        // Asynchronous reset mid-vector: weights wiped, partial vector discarded
        send_beats(20, 0, 0);
        #2 rst_n = 0;
        #1;
        chk("arst_acc0", get_acc(0), 0);
        chk("arst_acc1", get_acc(1), 0);
        chk("arst_sign", int'(sign_out), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_busy", int'(busy), 0);
        for (int s = 0; s < STEPS; s++) wm[s] = '0;
        @(posedge clk);
        #1 rst_n = 1;
        tick();
        chk("arst_in_ready", int'(in_ready), 1);
        send_beats(STEPS, 0, 0);
        check_result("after_rst", -108, -108, 2'b00);
        release_result(1, -108, -108, 2'b00);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bnn_fc_mac.md
BNN_FC_MAC -- requirements
Module: bnn_fc_mac

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, named clk and rst_n as elsewhere in the codebase.
REQ-002 Parameters SHALL be as follows, one per line: name, default, meaning.
  IN_LANES  3   binary activations consumed per beat.
  STEPS     36  beats per input vector (vector length = IN_LANES*STEPS).
  NUM_OUT   2   output neurons computed in parallel.
  ACC_W     8   signed accumulator width; SHALL be >= clog2(IN_LANES*STEPS+1)+1.
REQ-003 Ports SHALL be as follows, one per line: name, direction, width, meaning.
  clk        in   1                   clock.
  rst_n      in   1                   async active-low reset.
  clear      in   1                   synchronous abort of the current vector.
  w_we       in   1                   weight row write enable.
  w_addr     in   clog2(STEPS)        weight row index (step number).
  w_data     in   NUM_OUT*IN_LANES    weight row; bit o*IN_LANES+l = weight of lane l for output o.
  in_valid   in   1                   activation beat valid.
  in_ready   out  1                   block accepts a beat.
  in_data    in   IN_LANES            activation bits; bit l = lane l.
  out_valid  out  1                   result valid.
  out_ready  in   1                   consumer takes result.
  acc_out    out  NUM_OUT*ACC_W       signed sums; output o at [o*ACC_W +: ACC_W].
  sign_out   out  NUM_OUT             binarised result per output.
  busy       out  1                   high in ACC or DONE.

Function
REQ-004 Binary encoding SHALL be: bit 1 = +1, bit 0 = -1, for both weights and activations.
REQ-005 Weight storage SHALL be STEPS rows of NUM_OUT*IN_LANES bits; a write SHALL take effect on the clk edge where w_we=1 and the state is IDLE. Writes in ACC or DONE SHALL be ignored, as SHALL writes with w_addr >= STEPS.
REQ-006 The FSM SHALL have three states: IDLE, ACC and DONE.
REQ-007 in_ready SHALL be 1 in IDLE and ACC and 0 in DONE; a beat is accepted when in_valid and in_ready are both 1.
REQ-008 A beat SHALL contribute, for each output o, the sum over lanes l of (+1 if in_data[l] XNOR w[step][o*IN_LANES+l] = 1, else -1).
REQ-009 The first beat accepted in IDLE SHALL load acc[o] with its contribution, set step=1 and enter ACC; each later beat accepted in ACC SHALL add its contribution to acc[o] and increment step.
REQ-010 The beat accepted at step=STEPS-1 SHALL wrap step to 0 and move the FSM to DONE; out_valid SHALL assert on the next cycle (1 cycle after the final beat is accepted).
REQ-011 Cycles without an accepted beat (in_valid low) SHALL leave acc and step unchanged; stalls of any length SHALL be tolerated.
REQ-012 In DONE, acc_out and sign_out SHALL be stable; on the first cycle with out_ready=1 the FSM SHALL return to IDLE and out_valid SHALL drop.
REQ-013 sign_out[o] SHALL be 1 when acc[o] >= 0 and 0 when acc[o] < 0, so a zero sum binarises to +1.
REQ-014 The accumulator SHALL be two's complement with no saturation; REQ-002 sizing guarantees no overflow.
REQ-015 clear=1 SHALL force IDLE, step=0, acc=0 and out_valid=0 on the next edge. Clear SHALL take priority over a simultaneous beat or out_ready, and SHALL NOT alter weights.
REQ-016 A w_we pulse coincident with a beat accepted in IDLE SHALL be ignored, because the state leaves IDLE on that edge.

Reset
REQ-017 While rst_n=0, the block SHALL set state=IDLE, step=0, acc=0, acc_out=0, sign_out=0, out_valid=0, busy=0 and all weight bits=0, asynchronously; in_ready SHALL be 1 after release.
REQ-018 Reset asserted mid-vector SHALL discard the partial vector with no result produced.

Verification
REQ-019 The bench SHALL cover the following directed scenarios, one per line: stimulus -> required response (default parameters).
  Write all rows 6'b111111, send 36 beats of 3'b111 -> out_valid 1 cycle after beat 36, acc_out = {+108,+108}, sign_out = 2'b11.
  Same weights, 36 beats of 3'b000 -> acc_out = {-108,-108}, sign_out = 2'b00.
  Rows 6'b000111 (out0 = +1, out1 = -1), 36 beats of 3'b111 -> out0 = +108, out1 = -108, sign_out = 2'b01.
  Weights all 1, 18 beats 3'b111 then 18 beats 3'b000, random in_valid gaps, out_ready low 5 cycles -> acc = 0 for both, sign_out = 2'b11, outputs stable and in_ready = 0 throughout the wait.
  clear after beat 10, then a full vector of 3'b111 -> result equals the fresh-vector result; weights unchanged.
  rst_n pulsed low after beat 20 -> all outputs 0 immediately and weights 0; a following full 3'b111 vector gives -108 for both outputs.
